// File: rtl/phv_deparser_emit.sv
// phv_deparser_emit
// Rebuilds packets by merging the original packet words with the processed
// PHV header slices. Original words are buffered in a packet FIFO and PHV
// slices in a PHV FIFO. Once a complete packet and a start-flagged slice are
// both available, the packet is replayed. Each word keeps its control bits
// [133:128], and its data comes from the matching 128-bit slice segment.
// When the header runs out before the packet ends, the rest of the packet
// passes through unchanged.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_pkt_valid, i_pkt        original packet words (134b)
//   i_phv_valid, i_phv        processed PHV slices (header + tag)
//   o_pkt_valid, o_pkt        rebuilt packet words (registered)
//   o_pkt_alfull/o_phv_alfull FIFO almost-full flags (registered)
//   o_err_cnt                 saturating error count (registered)
module phv_deparser_emit #(
    parameter int HEAD_WIDTH    = 1024,
    parameter int TAG_WIDTH     = 8,
    parameter int TAG_START_BIT = 0,
    parameter int TAG_TAIL_BIT  = 1,
    parameter int PKT_DEPTH     = 512,
    parameter int PHV_DEPTH     = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_pkt_valid,
    input  logic [133:0]                    i_pkt,
    input  logic                            i_phv_valid,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_phv,
    output logic                            o_pkt_valid,
    output logic [133:0]                    o_pkt,
    output logic                            o_pkt_alfull,
    output logic                            o_phv_alfull,
    output logic [15:0]                     o_err_cnt
);
    localparam int PKT_NUM = HEAD_WIDTH / 128;
    localparam int SEG_W   = (PKT_NUM > 1) ? $clog2(PKT_NUM) : 1;
    localparam int PHV_W   = HEAD_WIDTH + TAG_WIDTH;
    localparam int PP_W    = (PKT_DEPTH > 1) ? $clog2(PKT_DEPTH) : 1;
    localparam int PC_W    = $clog2(PKT_DEPTH + 1);
    localparam int HP_W    = (PHV_DEPTH > 1) ? $clog2(PHV_DEPTH) : 1;
    localparam int HC_W    = $clog2(PHV_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_PASS  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Storage arrays are plain RAM, so they carry no reset.
    logic [133:0]     pkt_mem [PKT_DEPTH];
    logic [PHV_W-1:0] phv_mem [PHV_DEPTH];

    logic [PP_W-1:0]  pkt_wr_ptr_q, pkt_wr_ptr_d, pkt_rd_ptr_q, pkt_rd_ptr_d;
    logic [PC_W-1:0]  pkt_used_q, pkt_used_d, pkt_tails_q, pkt_tails_d;
    logic [HP_W-1:0]  phv_wr_ptr_q, phv_wr_ptr_d, phv_rd_ptr_q, phv_rd_ptr_d;
    logic [HC_W-1:0]  phv_used_q, phv_used_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             out_valid_q, out_valid_d;
    logic [133:0]     out_pkt_q, out_pkt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             pkt_alfull_q, pkt_alfull_d, phv_alfull_q, phv_alfull_d;

    logic             pkt_full_s, pkt_empty_s, pkt_wr_s, pkt_drop_s, pkt_pop_s, pkt_last_s;
    logic             phv_full_s, phv_empty_s, phv_wr_s, phv_drop_s, phv_pop_s;
    logic             phv_start_s, phv_tail_s, seg_last_s, emit_go_s, fsm_err_s;
    logic [133:0]     pkt_head_s;
    logic [PHV_W-1:0] phv_head_s;
    logic [127:0]     seg_data_s;
    logic [16:0]      err_sum_s;

    // FIFO status and head words; a write to a full FIFO is accepted only when a pop frees the slot.
    always_comb begin
        pkt_full_s  = (pkt_used_q == PC_W'(PKT_DEPTH));
        pkt_empty_s = (pkt_used_q == '0);
        phv_full_s  = (phv_used_q == HC_W'(PHV_DEPTH));
        phv_empty_s = (phv_used_q == '0);
        pkt_wr_s    = i_pkt_valid & (~pkt_full_s | pkt_pop_s);
        pkt_drop_s  = i_pkt_valid & pkt_full_s & ~pkt_pop_s;
        phv_wr_s    = i_phv_valid & (~phv_full_s | phv_pop_s);
        phv_drop_s  = i_phv_valid & phv_full_s & ~phv_pop_s;
        pkt_head_s  = pkt_mem[pkt_rd_ptr_q];
        phv_head_s  = phv_mem[phv_rd_ptr_q];
        pkt_last_s  = pkt_head_s[133];
        phv_start_s = phv_head_s[HEAD_WIDTH + TAG_START_BIT];
        phv_tail_s  = phv_head_s[HEAD_WIDTH + TAG_TAIL_BIT];
        seg_last_s  = (seg_q == SEG_W'(PKT_NUM - 1));
        emit_go_s   = ~phv_empty_s & ~pkt_empty_s;
    end

    // Select the 128-bit segment of the head slice addressed by the segment counter.
    always_comb begin
        seg_data_s = 128'd0;
        for (int j = 0; j < PKT_NUM; j++) begin
            seg_data_s = seg_data_s
                       | ({128{seg_q == SEG_W'(j)}} & phv_head_s[HEAD_WIDTH-128*j-1 -: 128]);
        end
    end

    // FIFO pointer, occupancy, complete-packet count and almost-full next values.
    always_comb begin
        pkt_wr_ptr_d = pkt_wr_s ? ((pkt_wr_ptr_q == PP_W'(PKT_DEPTH - 1)) ? '0 : pkt_wr_ptr_q + PP_W'(1)) : pkt_wr_ptr_q;
        pkt_rd_ptr_d = pkt_pop_s ? ((pkt_rd_ptr_q == PP_W'(PKT_DEPTH - 1)) ? '0 : pkt_rd_ptr_q + PP_W'(1)) : pkt_rd_ptr_q;
        phv_wr_ptr_d = phv_wr_s ? ((phv_wr_ptr_q == HP_W'(PHV_DEPTH - 1)) ? '0 : phv_wr_ptr_q + HP_W'(1)) : phv_wr_ptr_q;
        phv_rd_ptr_d = phv_pop_s ? ((phv_rd_ptr_q == HP_W'(PHV_DEPTH - 1)) ? '0 : phv_rd_ptr_q + HP_W'(1)) : phv_rd_ptr_q;
        pkt_used_d   = pkt_used_q + PC_W'(pkt_wr_s) - PC_W'(pkt_pop_s);
        phv_used_d   = phv_used_q + HC_W'(phv_wr_s) - HC_W'(phv_pop_s);
        // A tail word marks a complete packet; write and read of tails in one cycle cancel.
        pkt_tails_d  = pkt_tails_q + PC_W'(pkt_wr_s & i_pkt[133]) - PC_W'(pkt_pop_s & pkt_last_s);
        pkt_alfull_d = (pkt_used_d >= PC_W'(PKT_DEPTH - 16));
        phv_alfull_d = (phv_used_d >= HC_W'(PHV_DEPTH - 2));
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (~phv_empty_s & phv_start_s & (pkt_tails_q != '0)) state_d = ST_EMIT;
                else state_d = ST_IDLE;
            end
            ST_EMIT: begin
                if (~emit_go_s) state_d = ST_EMIT;
                else if (pkt_last_s) state_d = phv_tail_s ? ST_IDLE : ST_DRAIN;
                else if (seg_last_s & phv_tail_s) state_d = ST_PASS;
                else state_d = ST_EMIT;
            end
            ST_PASS: begin
                if (~pkt_empty_s & pkt_last_s) state_d = ST_IDLE;
                else state_d = ST_PASS;
            end
            ST_DRAIN: begin
                if (~phv_empty_s & phv_tail_s) state_d = ST_IDLE;
                else state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO pops, segment counter, output word and error pulse.
    always_comb begin
        pkt_pop_s   = 1'b0;
        phv_pop_s   = 1'b0;
        fsm_err_s   = 1'b0;
        seg_d       = seg_q;
        out_valid_d = 1'b0;
        out_pkt_d   = 134'd0;
        case (state_q)
            ST_IDLE: begin
                seg_d = '0;
                // A head slice that does not open a packet cannot be matched; discard it.
                if (~phv_empty_s & ~phv_start_s) begin
                    phv_pop_s = 1'b1;
                    fsm_err_s = 1'b1;
                end else begin
                    phv_pop_s = 1'b0;
                end
            end
            ST_EMIT: begin
                if (emit_go_s) begin
                    pkt_pop_s   = 1'b1;
                    out_valid_d = 1'b1;
                    out_pkt_d   = {pkt_head_s[133:128], seg_data_s};
                    if (pkt_last_s) begin
                        phv_pop_s = 1'b1;
                        fsm_err_s = ~phv_tail_s;
                        seg_d     = '0;
                    end else if (seg_last_s) begin
                        phv_pop_s = 1'b1;
                        seg_d     = '0;
                    end else begin
                        seg_d     = seg_q + SEG_W'(1);
                    end
                end else begin
                    pkt_pop_s = 1'b0;
                end
            end
            ST_PASS: begin
                if (~pkt_empty_s) begin
                    pkt_pop_s   = 1'b1;
                    out_valid_d = 1'b1;
                    out_pkt_d   = pkt_head_s;
                end else begin
                    pkt_pop_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (~phv_empty_s) phv_pop_s = 1'b1;
                else phv_pop_s = 1'b0;
            end
            default: begin
                seg_d = '0;
            end
        endcase
    end

    // Error counter: up to three events per cycle, saturating at all-ones.
    always_comb begin
        err_sum_s = {1'b0, err_cnt_q} + 17'(pkt_drop_s) + 17'(phv_drop_s) + 17'(fsm_err_s);
        if (err_sum_s[16]) err_cnt_d = 16'hFFFF;
        else err_cnt_d = err_sum_s[15:0];
    end

    // FIFO storage writes.
    always_ff @(posedge i_clk) begin
        if (pkt_wr_s) pkt_mem[pkt_wr_ptr_q] <= i_pkt;
        if (phv_wr_s) phv_mem[phv_wr_ptr_q] <= i_phv;
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Datapath, FIFO control and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pkt_wr_ptr_q <= '0;
            pkt_rd_ptr_q <= '0;
            pkt_used_q   <= '0;
            pkt_tails_q  <= '0;
            phv_wr_ptr_q <= '0;
            phv_rd_ptr_q <= '0;
            phv_used_q   <= '0;
            seg_q        <= '0;
            out_valid_q  <= 1'b0;
            out_pkt_q    <= 134'd0;
            err_cnt_q    <= 16'd0;
            pkt_alfull_q <= 1'b0;
            phv_alfull_q <= 1'b0;
        end else begin
            pkt_wr_ptr_q <= pkt_wr_ptr_d;
            pkt_rd_ptr_q <= pkt_rd_ptr_d;
            pkt_used_q   <= pkt_used_d;
            pkt_tails_q  <= pkt_tails_d;
            phv_wr_ptr_q <= phv_wr_ptr_d;
            phv_rd_ptr_q <= phv_rd_ptr_d;
            phv_used_q   <= phv_used_d;
            seg_q        <= seg_d;
            out_valid_q  <= out_valid_d;
            out_pkt_q    <= out_pkt_d;
            err_cnt_q    <= err_cnt_d;
            pkt_alfull_q <= pkt_alfull_d;
            phv_alfull_q <= phv_alfull_d;
        end
    end

    assign o_pkt_valid  = out_valid_q;
    assign o_pkt        = out_pkt_q;
    assign o_err_cnt    = err_cnt_q;
    assign o_pkt_alfull = pkt_alfull_q;
    assign o_phv_alfull = phv_alfull_q;
endmodule

// File: tb/tb_phv_deparser_emit.sv
// Scoreboard bench for phv_deparser_emit. The reference model derives each
// output word from the packet/slice lists: word k takes segment k mod 8 of
// the current slice. It moves to the next slice after segment 7. Once a
// tail slice runs out it passes original words through. When the packet
// ends on a slice that is not a tail slice, it records one error.
module tb_phv_deparser_emit;
    localparam int HEAD_WIDTH = 1024;
    localparam int TAG_WIDTH  = 8;
    localparam int PHV_W      = HEAD_WIDTH + TAG_WIDTH;
    localparam int PKT_NUM    = HEAD_WIDTH / 128;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_pkt_valid = 1'b0;
    logic [133:0]     i_pkt = '0;
    logic             i_phv_valid = 1'b0;
    logic [PHV_W-1:0] i_phv = '0;
    logic             o_pkt_valid;
    logic [133:0]     o_pkt;
    logic             o_pkt_alfull;
    logic             o_phv_alfull;
    logic [15:0]      o_err_cnt;

    int errors = 0;
    int checks = 0;
    int mon_cnt = 0;
    int exp_err = 0;
    logic [133:0] exp_q[$];

    phv_deparser_emit dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_pkt_valid(i_pkt_valid), .i_pkt(i_pkt),
        .i_phv_valid(i_phv_valid), .i_phv(i_phv),
        .o_pkt_valid(o_pkt_valid), .o_pkt(o_pkt),
        .o_pkt_alfull(o_pkt_alfull), .o_phv_alfull(o_phv_alfull),
        .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [133:0] got, input logic [133:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [PHV_W-1:0] mk_slice(input bit start, input bit tail);
        logic [PHV_W-1:0] s;
        logic [TAG_WIDTH-1:0] tag;
        for (int b = 0; b < HEAD_WIDTH / 32; b++) s[b*32 +: 32] = $urandom();
        tag = TAG_WIDTH'($urandom());
        tag[0] = start;
        tag[1] = tail;
        s[HEAD_WIDTH +: TAG_WIDTH] = tag;
        return s;
    endfunction

    function automatic logic [127:0] seg_of(input logic [PHV_W-1:0] s, input int j);
        return s[HEAD_WIDTH-128*j-1 -: 128];
    endfunction

    // Builds a packet of n words with ns slices, predicts output, then drives both FIFOs.
    task automatic send_pkt(input int n, input int ns);
        logic [133:0]     w[$];
        logic [PHV_W-1:0] sl[$];
        logic [1:0]       tg;
        bit               pass;
        int               si;
        int               sg;
        for (int i = 0; i < ns; i++) sl.push_back(mk_slice(i == 0, i == ns - 1));
        for (int k = 0; k < n; k++) begin
            if (n == 1)          tg = 2'b11;
            else if (k == 0)     tg = 2'b01;
            else if (k == n - 1) tg = 2'b10;
            else                 tg = 2'b00;
            w.push_back({tg, 4'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()});
        end
        pass = 1'b0;
        si = 0;
        for (int k = 0; k < n; k++) begin
            if (pass) begin
                exp_q.push_back(w[k]);
            end else begin
                sg = k % PKT_NUM;
                exp_q.push_back({w[k][133:128], seg_of(sl[si], sg)});
                if (k == n - 1) begin
                    if (sl[si][HEAD_WIDTH + 1] == 1'b0) exp_err++;
                end else if (sg == PKT_NUM - 1) begin
                    if (sl[si][HEAD_WIDTH + 1]) pass = 1'b1;
                    else si++;
                end
            end
        end
        for (int i = 0; i < ns; i++) begin
            @(negedge i_clk);
            i_phv_valid = 1'b1;
            i_phv = sl[i];
        end
        @(negedge i_clk);
        i_phv_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge i_clk);
                i_pkt_valid = 1'b0;
            end
            @(negedge i_clk);
            i_pkt_valid = 1'b1;
            i_pkt = w[k];
        end
        @(negedge i_clk);
        i_pkt_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 2000) begin
            @(negedge i_clk);
            b++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
        end
        repeat (8) @(negedge i_clk);
    endtask

    // Monitor: compares every emitted word against the scoreboard and checks the inter-packet gap.
    initial begin
        logic [133:0] e;
        bit prev_last;
        prev_last = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                prev_last = 1'b0;
            end else begin
                if (prev_last) begin
                    checks++;
                    if (o_pkt_valid) begin
                        errors++;
                        $display("FAIL pkt_gap got_valid=1 exp_valid=0");
                    end
                end
                if (o_pkt_valid) begin
                    checks++;
                    mon_cnt++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word got=%0h exp=none", o_pkt);
                    end else begin
                        e = exp_q.pop_front();
                        if (o_pkt !== e) begin
                            errors++;
                            $display("FAIL pkt_word got=%0h exp=%0h", o_pkt, e);
                        end
                    end
                end
                prev_last = o_pkt_valid && o_pkt[133];
            end
        end
    end

    initial begin
        int base;
        int b;
        repeat (3) @(negedge i_clk);
        chk("rst_valid", 134'(o_pkt_valid), 134'd0);
        chk("rst_pkt", o_pkt, 134'd0);
        chk("rst_err", 134'(o_err_cnt), 134'd0);
        chk("rst_alfull", 134'({o_pkt_alfull, o_phv_alfull}), 134'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Directed shapes: 4 words/1 slice, 20/3, 12/1 (pass-through), 3/2 (drain), single word.
        send_pkt(4, 1);  wait_drain();
        send_pkt(20, 3); wait_drain();
        chk("err_after_20w", 134'(o_err_cnt), 134'd0);
        send_pkt(12, 1); wait_drain();
        send_pkt(3, 2);  wait_drain();
        chk("err_after_drain", 134'(o_err_cnt), 134'(exp_err));
        send_pkt(5, 1);  wait_drain();
        send_pkt(1, 1);  wait_drain();

        // A lone slice without the start bit is discarded as an error.
        @(negedge i_clk);
        i_phv_valid = 1'b1;
        i_phv = mk_slice(1'b0, 1'b1);
        @(negedge i_clk);
        i_phv_valid = 1'b0;
        exp_err++;
        repeat (4) @(negedge i_clk);
        chk("err_bad_start", 134'(o_err_cnt), 134'(exp_err));

        // Randomized packets, sometimes two in flight.
        for (int p = 0; p < 20; p++) begin
            send_pkt($urandom_range(1, 24), $urandom_range(1, 4));
            if (p % 2 == 1) wait_drain();
        end
        wait_drain();
        chk("err_random", 134'(o_err_cnt), 134'(exp_err));

        // PHV FIFO overflow: 16 slices fill it, the 17th is dropped.
        for (int i = 0; i < 17; i++) begin
            @(negedge i_clk);
            i_phv_valid = 1'b1;
            i_phv = mk_slice(1'b1, 1'b1);
        end
        @(negedge i_clk);
        i_phv_valid = 1'b0;
        exp_err++;
        repeat (2) @(negedge i_clk);
        chk("phv_alfull", 134'(o_phv_alfull), 134'd1);
        chk("pkt_alfull", 134'(o_pkt_alfull), 134'd0);
        chk("err_overflow", 134'(o_err_cnt), 134'(exp_err));

        i_rst_n = 1'b0;
        exp_err = 0;
        #1;
        chk("rst2_valid", 134'(o_pkt_valid), 134'd0);
        chk("rst2_err", 134'(o_err_cnt), 134'd0);
        chk("rst2_alfull", 134'({o_pkt_alfull, o_phv_alfull}), 134'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (10) @(negedge i_clk);

        // Reset in the middle of a 6-word emission.
        base = mon_cnt;
        send_pkt(6, 1);
        b = 0;
        while (mon_cnt < base + 2 && b < 200) begin
            @(negedge i_clk);
            b++;
        end
        chk("mid_reset_reached", 134'(mon_cnt >= base + 2), 134'd1);
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        exp_q.delete();
        exp_err = 0;
        #1;
        chk("mid_rst_valid_now", 134'(o_pkt_valid), 134'd0);
        @(posedge i_clk);
        #1;
        chk("mid_rst_valid_edge", 134'(o_pkt_valid), 134'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        base = mon_cnt;
        repeat (20) @(negedge i_clk);
        chk("no_stale_words", 134'(mon_cnt - base), 134'd0);
        send_pkt(7, 1);
        wait_drain();
        send_pkt(9, 2);
        wait_drain();
        chk("err_final", 134'(o_err_cnt), 134'(exp_err));
        chk("queue_empty", 134'(exp_q.size()), 134'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
